// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants and lock-state type.
// Shared by the timing generator and the sync receiver.
package vga_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_SYNC_POL = 0;
  localparam int VGA_LOCK_FRAMES = 2;

  localparam int VGA_H_TOTAL =
    VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL =
    VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef enum logic [1:0] {
    SEARCH,
    ACQUIRE,
    LOCKED
  } lock_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Sync input conditioner: 2-flop synchronizer, polarity
// normalisation and pix_en-qualified leading-edge pulse.
import vga_timing_pkg::*;

module sync_edge_det #(
  parameter int POL = VGA_SYNC_POL
) (
  input  logic clk,
  input  logic reset,
  input  logic pix_en,
  input  logic sync_in,
  output logic lead
);

  localparam logic ACT = logic'(POL != 0);

  logic asrt;
  logic s1;
  logic s2;
  logic prev;

  assign asrt = ~(sync_in ^ ACT);

  // Synchronize the asserted-high level; history updates on pix_en
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1 <= asrt;
      s2 <= s1;
      if (pix_en) prev <= s2;
    end
  end

  assign lead = pix_en & s2 & ~prev;

endmodule

// File: rtl/vga_sync_receiver.sv
// Recovers x/y/de from hsync/vsync, checks line and frame
// lengths and tracks lock against the expected timing.
import vga_timing_pkg::*;

module vga_sync_receiver #(
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int H_FP        = VGA_H_FP,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_BP        = VGA_H_BP,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int V_FP        = VGA_V_FP,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_BP        = VGA_V_BP,
  parameter int SYNC_POL    = VGA_SYNC_POL,
  parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       err_clr,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       de,
  output logic       frame_start,
  output logic       locked,
  output logic       err_h,
  output logic       err_v
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_TOT_W = 11'(H_TOTAL);
  localparam logic [10:0] V_TOT_W = 11'(V_TOTAL);

  localparam logic [9:0] H_LO = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_HI = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0] V_LO = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_HI = 10'(V_SYNC + V_BP + V_ACTIVE - 1);

  localparam logic [9:0] CNT_MAX  = 10'd1023;
  localparam logic [3:0] LOCK_TGT = 4'(LOCK_FRAMES);

  logic        hs_edge;
  logic        vs_edge;

  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [9:0]  h_nxt;
  logic [9:0]  v_nxt;
  logic        vs_pend;
  logic        vs_pend_nxt;

  logic        h_err;
  logic        v_err;
  logic        frame_evt;

  lock_state_t state;
  lock_state_t state_nxt;
  logic [3:0]  good_cnt;
  logic [3:0]  good_nxt;

  logic        h_act;
  logic        v_act;
  logic        act;
  logic        origin;
  logic        tracking;

  sync_edge_det #(
    .POL(SYNC_POL)
  ) u_hs (
    .clk    (clk),
    .reset  (reset),
    .pix_en (pix_en),
    .sync_in(hsync_in),
    .lead   (hs_edge)
  );

  sync_edge_det #(
    .POL(SYNC_POL)
  ) u_vs (
    .clk    (clk),
    .reset  (reset),
    .pix_en (pix_en),
    .sync_in(vsync_in),
    .lead   (vs_edge)
  );

  // Next counts, length checks and the vs-aligned frame event
  always_comb begin
    h_nxt       = h_cnt;
    v_nxt       = v_cnt;
    vs_pend_nxt = vs_pend;
    h_err       = 1'b0;
    v_err       = 1'b0;
    frame_evt   = 1'b0;
    if (pix_en) begin
      if (hs_edge) begin
        h_nxt = '0;
        h_err = ({1'b0, h_cnt} + 11'd1) != H_TOT_W;
        if (vs_edge || vs_pend) begin
          v_nxt       = '0;
          vs_pend_nxt = 1'b0;
          frame_evt   = 1'b1;
          v_err = ({1'b0, v_cnt} + 11'd1) != V_TOT_W;
        end else if (v_cnt != CNT_MAX) begin
          v_nxt = v_cnt + 10'd1;
          v_err = (v_nxt == CNT_MAX);
        end
      end else begin
        if (h_cnt != CNT_MAX) begin
          h_nxt = h_cnt + 10'd1;
          h_err = (h_nxt == CNT_MAX);
        end
        if (vs_edge) vs_pend_nxt = 1'b1;
      end
    end
  end

  // Lock FSM: frames are delimited by the vs-aligned v reset
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    unique case (state)
      SEARCH: begin
        if (frame_evt) begin
          state_nxt = ACQUIRE;
          good_nxt  = '0;
        end
      end
      ACQUIRE: begin
        if (h_err || v_err) begin
          state_nxt = SEARCH;
        end else if (frame_evt) begin
          good_nxt = good_cnt + 4'd1;
          if (good_nxt >= LOCK_TGT) state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (h_err || v_err) state_nxt = SEARCH;
      end
      default: state_nxt = SEARCH;
    endcase
  end

  // Counter and FSM state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      vs_pend  <= 1'b0;
      state    <= SEARCH;
      good_cnt <= '0;
    end else begin
      h_cnt    <= h_nxt;
      v_cnt    <= v_nxt;
      vs_pend  <= vs_pend_nxt;
      state    <= state_nxt;
      good_cnt <= good_nxt;
    end
  end

  assign tracking = (state != SEARCH);
  assign locked   = (state == LOCKED);

  // Sticky error flags; a new error beats a clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_h <= 1'b0;
      err_v <= 1'b0;
    end else begin
      if (h_err && tracking) err_h <= 1'b1;
      else if (err_clr)      err_h <= 1'b0;
      if (v_err && tracking) err_v <= 1'b1;
      else if (err_clr)      err_v <= 1'b0;
    end
  end

  assign h_act  = (h_nxt >= H_LO) && (h_nxt <= H_HI);
  assign v_act  = (v_nxt >= V_LO) && (v_nxt <= V_HI);
  assign act    = h_act && v_act;
  assign origin = (h_nxt == H_LO) && (v_nxt == V_LO);

  // Registered pixel outputs from the counts of this pix_en
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x           <= '0;
      y           <= '0;
      de          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && origin;
      if (pix_en) begin
        x  <= act ? (h_nxt - H_LO) : '0;
        y  <= act ? (v_nxt - V_LO) : '0;
        de <= act && (state_nxt == LOCKED);
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver using a reduced
// 16x9 timing so that many frames fit in a short run.
module tb_vga_sync_receiver;

  localparam int HA = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 3;
  localparam int VA = 4;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pix_en = 1'b0;
  logic       hsync_in = 1'b1;
  logic       vsync_in = 1'b1;
  logic       err_clr = 1'b0;
  logic [9:0] x;
  logic [9:0] y;
  logic       de;
  logic       frame_start;
  logic       locked;
  logic       err_h;
  logic       err_v;

  vga_sync_receiver #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(0), .LOCK_FRAMES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_en     (pix_en),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .err_clr    (err_clr),
    .x          (x),
    .y          (y),
    .de         (de),
    .frame_start(frame_start),
    .locked     (locked),
    .err_h      (err_h),
    .err_v      (err_v)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   h;
    int   v;
    int   ex;
    int   ey;
    logic ede;
    logic efs;
  } vec_t;

  vec_t tab[8];

  int   n_pass = 0;
  int   n_tot = 0;
  int   hc = 0;
  int   vc = 0;
  int   line_len = 16;
  int   frame_len = 9;
  int   pix_idx = 0;
  int   last_fs = 0;
  int   fs_gap = 0;
  int   fs_cnt = 0;
  int   fs_base;
  int   cur_h;
  int   cur_v;
  logic de_pre;
  logic lk_pre;
  bit   chk_tab = 1'b0;

  task automatic chk(input string name, input int act,
                     input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d",
                  name, act, exp);
  endtask

  // One pixel: pins set, 2 clk sync, pix_en clk, sample
  task automatic drive(input logic hs_a, input logic vs_a);
    @(negedge clk);
    hsync_in = ~hs_a;
    vsync_in = ~vs_a;
    @(negedge clk);
    @(negedge clk);
    de_pre = de;
    lk_pre = locked;
    pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
  endtask

  task automatic gen();
    cur_h = hc;
    cur_v = vc;
    drive(hc < HS, vc < VS);
    pix_idx++;
    if (frame_start) begin
      fs_cnt++;
      fs_gap  = pix_idx - last_fs;
      last_fs = pix_idx;
    end
    if (chk_tab) begin
      foreach (tab[i]) begin
        if (tab[i].h == cur_h && tab[i].v == cur_v) begin
          chk($sformatf("x@%0d,%0d", cur_h, cur_v),
              int'(x), tab[i].ex);
          chk($sformatf("y@%0d,%0d", cur_h, cur_v),
              int'(y), tab[i].ey);
          chk($sformatf("de@%0d,%0d", cur_h, cur_v),
              int'(de), int'(tab[i].ede));
          chk($sformatf("fs@%0d,%0d", cur_h, cur_v),
              int'(frame_start), int'(tab[i].efs));
          if (cur_h == 6 && cur_v == 4)
            chk("de_before_latency", int'(de_pre), 0);
        end
      end
    end
    hc++;
    if (hc >= line_len) begin
      hc = 0;
      vc++;
      if (vc >= frame_len) vc = 0;
    end
  endtask

  task automatic run_to(input int h, input int v);
    int n;
    n = 0;
    do begin
      gen();
      n++;
    end while (!(hc == h && vc == v) && n < 5000);
    if (!(hc == h && vc == v)) begin
      n_tot++;
      $display("FAIL run_to_bound: got %0d,%0d, want %0d,%0d",
               hc, vc, h, v);
    end
  endtask

  task automatic relock(input string tag);
    gen();
    run_to(0, 0);
    gen();
    run_to(0, 0);
    chk({tag, "_not_yet"}, int'(locked), 0);
    gen();
    chk({tag, "_locked"}, int'(locked), 1);
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    tab[0] = '{6, 4, 0, 0, 1'b1, 1'b1};
    tab[1] = '{13, 7, 7, 3, 1'b1, 1'b0};
    tab[2] = '{5, 4, 0, 0, 1'b0, 1'b0};
    tab[3] = '{14, 4, 0, 0, 1'b0, 1'b0};
    tab[4] = '{10, 5, 4, 1, 1'b1, 1'b0};
    tab[5] = '{6, 3, 0, 0, 1'b0, 1'b0};
    tab[6] = '{6, 8, 0, 0, 1'b0, 1'b0};
    tab[7] = '{13, 4, 7, 0, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_x", int'(x), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_de", int'(de), 0);
    chk("rst_fs", int'(frame_start), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err_h", int'(err_h), 0);
    chk("rst_err_v", int'(err_v), 0);
    reset = 1'b1;

    // Initial acquisition: lock on the 3rd vs edge
    gen();
    chk("acq_edge1", int'(locked), 0);
    run_to(0, 0);
    gen();
    chk("acq_edge2", int'(locked), 0);
    run_to(0, 0);
    chk("acq_pre_edge3", int'(locked), 0);
    gen();
    chk("acq_edge3", int'(locked), 1);
    chk("acq_err_h", int'(err_h), 0);
    chk("acq_err_v", int'(err_v), 0);

    // Locked frame swept against the vector table
    fs_base = fs_cnt;
    chk_tab = 1'b1;
    run_to(0, 0);
    chk_tab = 1'b0;
    chk("fs_per_frame", fs_cnt - fs_base, 1);
    run_to(7, 4);
    chk("fs_interval", fs_gap, 144);

    // Short line while locked
    run_to(0, 5);
    line_len = 15;
    run_to(0, 6);
    line_len = 16;
    gen();
    chk("short_lk_before", int'(lk_pre), 1);
    chk("short_lk_drop", int'(locked), 0);
    chk("short_err_h", int'(err_h), 1);
    chk("short_err_v", int'(err_v), 0);
    run_to(0, 0);
    relock("short_relock");
    chk("short_err_h_sticky", int'(err_h), 1);
    clr_pulse();
    chk("clr_err_h", int'(err_h), 0);

    // Short frame while locked, coincident hs+vs edge
    run_to(0, 1);
    frame_len = 8;
    run_to(0, 0);
    frame_len = 9;
    gen();
    chk("vfr_lk_before", int'(lk_pre), 1);
    chk("vfr_lk_drop", int'(locked), 0);
    chk("vfr_err_v", int'(err_v), 1);
    chk("vfr_no_err_h", int'(err_h), 0);
    run_to(7, 5);
    gen();
    chk("vfr_x", int'(x), 1);
    chk("vfr_y", int'(y), 1);
    chk("vfr_de", int'(de), 0);
    run_to(0, 0);
    relock("vfr_relock");
    clr_pulse();
    chk("clr_err_v", int'(err_v), 0);

    // hsync removed: h_cnt saturates 1007 pixels in
    run_to(0, 2);
    for (int i = 0; i < 1100; i++) begin
      drive(1'b0, 1'b0);
      if (i == 1006) chk("sat_lk_hold", int'(locked), 1);
      if (i == 1007) begin
        chk("sat_lk_drop", int'(locked), 0);
        chk("sat_err_h", int'(err_h), 1);
      end
    end
    chk("sat_lk_end", int'(locked), 0);
    hc = 0;
    vc = 0;
    relock("sat_relock");
    chk("sat_err_h_sticky", int'(err_h), 1);

    // Asynchronous reset mid-line
    run_to(9, 5);
    gen();
    chk("pre_rst_x", int'(x), 3);
    chk("pre_rst_y", int'(y), 1);
    chk("pre_rst_de", int'(de), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_x", int'(x), 0);
    chk("arst_y", int'(y), 0);
    chk("arst_de", int'(de), 0);
    chk("arst_locked", int'(locked), 0);
    chk("arst_err_h", int'(err_h), 0);
    chk("arst_err_v", int'(err_v), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    run_to(0, 0);
    relock("arst_relock");
    chk("arst_end_err_h", int'(err_h), 0);
    chk("arst_end_err_v", int'(err_v), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/vga_sync_receiver.md
Name: vga_sync_receiver

Overview:
- Receiving end of the VGA timing interface. Consumes hsync/vsync from a timing generator and recovers pixel coordinates (x, y) and a data-enable.
- Checks line and frame lengths against the 640x480@60 timing and reports lock status.
- Used as an on-chip monitor of the timing generator's outputs, and as the coordinate source for any downstream pixel consumer that sees only sync signals.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)
- LOCK_FRAMES, 2, consecutive good frames required to declare lock

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-low reset
- pix_en  in  1  one-cycle pixel enable (25 MHz rate); all counting advances only when high
- hsync_in  in  1  horizontal sync from the timing generator
- vsync_in  in  1  vertical sync from the timing generator
- err_clr  in  1  synchronous clear of the sticky error flags
- x  out  10  recovered column, 0..H_ACTIVE-1; 0 outside active area
- y  out  10  recovered row, 0..V_ACTIVE-1; 0 outside active area
- de  out  1  high while (x, y) is in the active area and locked=1
- frame_start  out  1  one pix_en-qualified clk pulse at x=0, y=0
- locked  out  1  timing matches parameters
- err_h  out  1  sticky: a line length ≠ H_TOTAL was seen
- err_v  out  1  sticky: a frame length ≠ V_TOTAL was seen

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset: all outputs 0, counters 0, FSM in SEARCH.
- Inputs pass through a 2-flop synchronizer, normalised by SYNC_POL to an asserted-high form (hs, vs).
- Edge detection is sampled on pix_en cycles only; a sync leading edge is hs/vs going 0->1.
- h_cnt (10 bit):
  - set to 0 on the pix_en cycle where the hs leading edge is detected; otherwise increments on pix_en.
  - saturates at 1023 if no edge arrives.
- Line-length check: at each hs edge, compare the previous h_cnt+1 with H_TOTAL; a mismatch is an h-error.
- v_cnt (10 bit):
  - increments at each hs edge.
  - set to 0 at the hs edge coinciding with, or first following, a vs leading edge.
  - saturates at 1023.
- Frame-length check: at the vs-aligned reset of v_cnt, compare the previous v_cnt+1 with V_TOTAL; a mismatch is a v-error.
- Active area:
  - h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] and v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1].
  - x = h_cnt-(H_SYNC+H_BP) and y = v_cnt-(V_SYNC+V_BP); both are 0 when outside the active area.
- x, y, de and frame_start are registered, with latency 1 clk after the pix_en cycle that produced the counts. Total sync-pin-to-output latency is 3 clk (2 sync + 1 register).
- Lock FSM (transitions evaluated on frame boundaries and on error events):
  - SEARCH: wait for the first vs edge -> ACQUIRE with good_cnt=0.
  - ACQUIRE: each frame with no h-error and no v-error increments good_cnt. When good_cnt reaches LOCK_FRAMES -> LOCKED. Any error -> SEARCH.
  - LOCKED: locked=1. Any h-error or v-error -> SEARCH immediately (locked drops in the same clk the error is registered). A saturated h_cnt or v_cnt also counts as an error.
- Sticky flags:
  - err_h/err_v are set only by errors detected while in ACQUIRE or LOCKED.
  - cleared by err_clr or reset. If a set and err_clr occur in the same cycle, set wins.
- Simultaneous hs and vs edges on the same pix_en: process the hs edge first, then the vs alignment, in one cycle. v_cnt becomes 0 and the frame check uses the pre-reset value.
- pix_en low: all state holds and frame_start cannot pulse.
- Reset asserted mid-frame: immediate return to the reset state; lock must be re-acquired (LOCK_FRAMES+1 vs edges minimum).

Decomposition:
- Shared package vga_timing_pkg holds:
  - the 640x480 timing constants, also consumed by the existing timing generator;
  - derived H_TOTAL/V_TOTAL;
  - the lock-state enum (SEARCH, ACQUIRE, LOCKED).
- One natural sub-module, sync_edge_det: 2-flop synchronizer, polarity normalisation and pix_en-qualified leading-edge pulse. Instantiated twice (hsync, vsync).

Test Plan:
- Drive the compliant 800x525 stream from the existing timing generator, pix_en every 4th clk -> locked=1 after the 3rd vs edge, err_h=err_v=0, frame_start every 420000 pix_en.
- While locked, check pixel (x=0, y=0) and (x=639, y=479) -> de=1 at both, with x/y exactly those values 3 clk after the pin; de=0 at h_cnt=143 and at h_cnt=784.
- Inject one 799-pixel line while locked -> locked falls in the error clk, err_h=1 and stays 1; relock after 2 good frames; err_clr pulse -> err_h=0.
- Send a 524-line frame -> err_v=1 and locked=0; coincident hs+vs edge gives v_cnt=0 with no spurious h-error.
- Remove hsync entirely for 1100 pixels -> h_cnt saturates at 1023, treated as an error, locked=0.
- Assert reset mid-line at x=300 -> all outputs 0 asynchronously; after release, lock returns only after the 3rd subsequent vs edge.
